// File: rtl/adder_tree_arb.sv
// adder_tree_arb: round-robin arbiter feeding one shared pipelined adder tree.
// Each accepted vector travels with its requester ID; the ID rides a tag
// pipeline matched to the tree depth so the sum comes back tagged.

// adder_tree_ppl: fully pipelined binary reduction tree, one register level
// per tree level, so latency is $clog2(DATA_NUM). Inputs are sign-extended to
// the output width and padded with zeros up to the next power of two.
module adder_tree_ppl #(
    parameter  int DATA_I_WIDTH = 16,
    parameter  int DATA_NUM     = 8,
    localparam int L            = $clog2(DATA_NUM),
    localparam int DATA_O_WIDTH = DATA_I_WIDTH + L
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 din_valid,
    input  logic [DATA_NUM*DATA_I_WIDTH-1:0]     din_data,
    output logic                                 dout_valid,
    output logic signed [DATA_O_WIDTH-1:0]       dout_data
);

    localparam int P = 1 << L;

    // leaf[j] are the tree inputs; sum[n] are the registered internal nodes
    // in heap order (children of n live at 2n+1 and 2n+2 of tap).
    logic signed [DATA_O_WIDTH-1:0] leaf [P];
    logic signed [DATA_O_WIDTH-1:0] sum  [P-1];
    logic signed [DATA_O_WIDTH-1:0] tap  [1:2*P-2];
    logic [L-1:0]                   vld;

    for (genvar j = 0; j < P; j++) begin : g_leaf
        if (j < DATA_NUM) begin : g_data
            assign leaf[j] = DATA_O_WIDTH'($signed(din_data[j*DATA_I_WIDTH +: DATA_I_WIDTH]));
        end else begin : g_pad
            assign leaf[j] = '0;
        end
    end

    // Flatten internal nodes and leaves into one child-index space.
    always_comb begin
        for (int n = 1; n < P - 1; n++) begin
            tap[n] = sum[n];
        end
        for (int j = 0; j < P; j++) begin
            tap[P-1+j] = leaf[j];
        end
    end

    // One adder level per clock; all leaves sit at equal depth so levels align.
    always_ff @(posedge clk) begin
        for (int n = 0; n < P - 1; n++) begin
            sum[n] <= rst ? '0 : tap[2*n+1] + tap[2*n+2];
        end
    end

    // Valid shift register matching the adder depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld[0] <= din_valid;
            for (int k = 1; k < L; k++) begin
                vld[k] <= vld[k-1];
            end
        end
    end

    assign dout_valid = vld[L-1];
    assign dout_data  = sum[0];

endmodule

module adder_tree_arb #(
    parameter  int DATA_I_WIDTH = 16,
    parameter  int DATA_NUM     = 8,
    parameter  int REQ_NUM      = 4,
    localparam int L            = $clog2(DATA_NUM),
    localparam int DATA_O_WIDTH = DATA_I_WIDTH + L,
    localparam int ID_WIDTH     = ($clog2(REQ_NUM) > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [REQ_NUM-1:0]                        req_valid,
    output logic [REQ_NUM-1:0]                        req_ready,
    input  logic [REQ_NUM*DATA_NUM*DATA_I_WIDTH-1:0]  req_data,
    output logic                                      res_valid,
    output logic [ID_WIDTH-1:0]                       res_id,
    output logic signed [DATA_O_WIDTH-1:0]            res_data,
    output logic                                      idle
);

    localparam int VW = DATA_NUM * DATA_I_WIDTH;

    logic [ID_WIDTH-1:0]             ptr;
    logic [ID_WIDTH-1:0]             grant_id;
    logic                            grant_any;

    logic                            iss_valid;
    logic [ID_WIDTH-1:0]             iss_id;
    logic [VW-1:0]                   iss_data;

    logic [L-1:0]                    tag_valid;
    logic [ID_WIDTH-1:0]             tag_id [L];

    logic                            tree_dout_valid;
    logic signed [DATA_O_WIDTH-1:0]  tree_dout_data;

    // First valid requester at or after ptr, wrapping; no output backpressure
    // so the grant depends only on req_valid and ptr.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        req_ready = '0;
        for (int off = 0; off < REQ_NUM; off++) begin
            if (!grant_any && req_valid[(int'(ptr) + off) % REQ_NUM]) begin
                grant_any = 1'b1;
                grant_id  = ID_WIDTH'((int'(ptr) + off) % REQ_NUM);
                req_ready[(int'(ptr) + off) % REQ_NUM] = 1'b1;
            end
        end
    end

    // Pointer moves just past the winner on every transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (grant_id == ID_WIDTH'(REQ_NUM - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    // Issue stage: register the accepted vector and its ID in front of the tree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid <= 1'b0;
            iss_id    <= '0;
            iss_data  <= '0;
        end else begin
            iss_valid <= grant_any;
            if (grant_any) begin
                iss_id   <= grant_id;
                iss_data <= req_data[int'(grant_id)*VW +: VW];
            end
        end
    end

    adder_tree_ppl #(
        .DATA_I_WIDTH (DATA_I_WIDTH),
        .DATA_NUM     (DATA_NUM)
    ) u_tree (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (iss_valid),
        .din_data   (iss_data),
        .dout_valid (tree_dout_valid),
        .dout_data  (tree_dout_data)
    );

    // Tag pipeline: valid/ID delayed to line up with the tree output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= '0;
            for (int k = 0; k < L; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_valid[0] <= iss_valid;
            tag_id[0]    <= iss_id;
            for (int k = 1; k < L; k++) begin
                tag_valid[k] <= tag_valid[k-1];
                tag_id[k]    <= tag_id[k-1];
            end
        end
    end

    // Output register: load on an aligned valid tag, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_data  <= '0;
        end else begin
            res_valid <= tag_valid[L-1];
            if (tag_valid[L-1]) begin
                res_id   <= tag_id[L-1];
                res_data <= tree_dout_data;
            end
        end
    end

    // The tree's own valid mirrors the last tag stage; including it keeps
    // idle conservative without changing its value.
    assign idle = !iss_valid && !(|tag_valid) && !res_valid && !tree_dout_valid;

endmodule
